// File: rtl/secret_slot_arbiter.sv
// Round-robin arbiter for one shared secret buffer; every change of owner passes through a scrub.
// Defining SCRUB_VERIFY_EN adds a one-cycle VERIFY state after SCRUB and enables the sticky scrub_err flag.
module secret_slot_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 32,
  parameter int SCRUB_CYCLES = 2,
  parameter int MAX_HOLD     = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_release,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_owner_id,
  input  logic                    i_wr_en,
  input  logic [DW-1:0]           i_wr_data,
  input  logic                    i_op_en,
  input  logic [DW-1:0]           i_op_data,
  output logic [DW-1:0]           o_op_out,
  output logic                    o_op_valid,
  output logic                    o_revoked,
  output logic                    o_scrub_done,
  output logic                    o_scrub_err
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int SW = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [SW-1:0] SCRUB_LAST = SW'(SCRUB_CYCLES - 1);

  // state  | meaning
  // IDLE   | no owner; round-robin pick among requesters
  // OWNED  | one owner may write the secret and run ops
  // SCRUB  | buffer held at zero for SCRUB_CYCLES cycles
  // VERIFY | (SCRUB_VERIFY_EN) confirm buffer, loaded and op_out are zero
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
`ifdef SCRUB_VERIFY_EN
    ST_VERIFY = 2'd3,
`endif
    ST_SCRUB = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [IW-1:0]     r_owner, r_ptr;
  logic [HW-1:0]     r_hold;
  logic [SW-1:0]     r_scrub_cnt;
  logic [DW-1:0]     r_buf, r_op_out;
  logic              r_loaded, r_op_valid, r_revoked, r_scrub_done;
  logic              w_any, w_take, w_exit, w_revoke, w_scrub_done;
  logic [IW-1:0]     w_win, w_idx, w_ptr_nxt;
  logic [NREQ-1:0]   w_onehot;

  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_idx    = '0;
    w_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    w_onehot[w_win] = 1'b1;
    w_ptr_nxt = IW'((int'(w_win) + 1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_exit       = 1'b0;
    w_revoke     = 1'b0;
    w_scrub_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_OWNED;
          w_take      = 1'b1;
        end
      end
      ST_OWNED: begin
        if (i_release[r_owner]) begin
          w_state_nxt = ST_SCRUB;
          w_exit      = 1'b1;
        end else if ((MAX_HOLD != 0) && (r_hold == HOLD_LAST)) begin
          w_state_nxt = ST_SCRUB;
          w_exit      = 1'b1;
          w_revoke    = 1'b1;
        end
      end
      ST_SCRUB: begin
        if (r_scrub_cnt == SCRUB_LAST) begin
`ifdef SCRUB_VERIFY_EN
          w_state_nxt  = ST_VERIFY;
`else
          w_state_nxt  = ST_IDLE;
          w_scrub_done = 1'b1;
`endif
        end
      end
`ifdef SCRUB_VERIFY_EN
      ST_VERIFY: begin
        w_state_nxt  = ST_IDLE;
        w_scrub_done = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_ptr        <= '0;
      r_hold       <= '0;
      r_scrub_cnt  <= '0;
      r_buf        <= '0;
      r_loaded     <= 1'b0;
      r_op_out     <= '0;
      r_op_valid   <= 1'b0;
      r_revoked    <= 1'b0;
      r_scrub_done <= 1'b0;
    end else begin
      r_op_valid   <= 1'b0;
      r_revoked    <= w_revoke;
      r_scrub_done <= w_scrub_done;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_grant <= w_onehot;
            r_owner <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= '0;
          end
        end
        ST_OWNED: begin
          if (w_exit) begin
            r_grant     <= '0;
            r_buf       <= '0;
            r_loaded    <= 1'b0;
            r_op_out    <= '0;
            r_scrub_cnt <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
            // op reads the pre-write buffer when both strobes coincide
            if (i_op_en && r_loaded) begin
              r_op_out   <= r_buf ^ i_op_data;
              r_op_valid <= 1'b1;
            end
            if (i_wr_en) begin
              r_buf    <= i_wr_data;
              r_loaded <= 1'b1;
            end
          end
        end
        ST_SCRUB: begin
          r_buf       <= '0;
          r_loaded    <= 1'b0;
          r_op_out    <= '0;
          r_scrub_cnt <= r_scrub_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCRUB_VERIFY_EN
  logic r_scrub_err;
  always_ff @(posedge clk) begin
    if (rst)
      r_scrub_err <= 1'b0;
    else if ((r_state == ST_VERIFY) && ((r_buf != '0) || r_loaded || (r_op_out != '0)))
      r_scrub_err <= 1'b1;
  end
  assign o_scrub_err = r_scrub_err;
`else
  assign o_scrub_err = 1'b0;
`endif

  assign o_grant      = r_grant;
  assign o_owner_id   = r_owner;
  assign o_op_out     = r_op_out;
  assign o_op_valid   = r_op_valid;
  assign o_revoked    = r_revoked;
  assign o_scrub_done = r_scrub_done;
endmodule

// File: tb/tb_secret_slot_arbiter.sv
// Scoreboard bench for secret_slot_arbiter: stimulus queues expected events, a negedge monitor pops and checks them.
module tb_secret_slot_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int SC   = 2;
  localparam int MH   = 8;
`ifdef SCRUB_VERIFY_EN
  localparam int SD = SC + 1;
`else
  localparam int SD = SC;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] rel = '0;
  logic            wr_en = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            op_en = 1'b0;
  logic [DW-1:0]   op_data = '0;
  logic [NREQ-1:0] o_grant;
  logic [1:0]      o_owner_id;
  logic [DW-1:0]   o_op_out;
  logic            o_op_valid, o_revoked, o_scrub_done, o_scrub_err;

  secret_slot_arbiter #(.NREQ(NREQ), .DW(DW), .SCRUB_CYCLES(SC), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_release(rel), .o_grant(o_grant),
    .o_owner_id(o_owner_id), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_op_en(op_en),
    .i_op_data(op_data), .o_op_out(o_op_out), .o_op_valid(o_op_valid),
    .o_revoked(o_revoked), .o_scrub_done(o_scrub_done), .o_scrub_err(o_scrub_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int at; } exp_t;
  exp_t q_op[$], q_gnt[$], q_sd[$], q_rev[$];
  int n_chk = 0, n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    case (kind)
      0: q_op.push_back(e);
      1: q_gnt.push_back(e);
      2: q_sd.push_back(e);
      default: q_rev.push_back(e);
    endcase
  endtask

  // owner cur releases with req held; next owner nxt becomes visible on return
  task automatic hand_over(input int cur, input int nxt);
    rel = NREQ'(1 << cur);
    push(2, 0, cyc + 1 + SD);
    push(1, nxt, cyc + 2 + SD);
    tick();
    rel = '0;
    chk("grant_drop", 32'(o_grant), 32'h0);
    repeat (1 + SD) tick();
  endtask

  initial begin : monitor
    logic [NREQ-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_op_valid === 1'b1) begin
          if (q_op.size() == 0) chk("op_valid_unexpected", 32'(o_op_valid), 32'h0);
          else begin
            e = q_op.pop_front();
            chk("op_out", o_op_out, e.val);
            chk("op_cycle", cyc, e.at);
          end
        end
        if ((o_grant !== prev) && (o_grant !== '0)) begin
          if (q_gnt.size() == 0) chk("grant_unexpected", 32'(o_grant), 32'h0);
          else begin
            e = q_gnt.pop_front();
            chk("grant", 32'(o_grant), 32'd1 << e.val);
            chk("owner_id", 32'(o_owner_id), e.val);
            chk("grant_cycle", cyc, e.at);
          end
        end
        if (o_scrub_done === 1'b1) begin
          if (q_sd.size() == 0) chk("scrub_done_unexpected", 32'(o_scrub_done), 32'h0);
          else begin
            e = q_sd.pop_front();
            chk("scrub_done_cycle", cyc, e.at);
          end
        end
        if (o_revoked === 1'b1) begin
          if (q_rev.size() == 0) chk("revoked_unexpected", 32'(o_revoked), 32'h0);
          else begin
            e = q_rev.pop_front();
            chk("revoked_cycle", cyc, e.at);
          end
        end
        prev = o_grant;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0;
    repeat (3) tick();
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_owner_id", 32'(o_owner_id), 32'h0);
    chk("rst_op_out", o_op_out, 32'h0);
    chk("rst_op_valid", 32'(o_op_valid), 32'h0);
    chk("rst_revoked", 32'(o_revoked), 32'h0);
    chk("rst_scrub_done", 32'(o_scrub_done), 32'h0);
    chk("rst_scrub_err", 32'(o_scrub_err), 32'h0);

    rst = 1'b0;
    mon_en = 1'b1;
    req = 4'b0001;
    push(1, 0, cyc + 1);
    tick();
    wr_en = 1'b1; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; op_en = 1'b1; op_data = 32'h0000FFFF;
    push(0, 32'hDEAD4110, cyc + 1);
    tick();
    wr_en = 1'b1; wr_data = 32'h11111111; op_data = 32'h0;
    push(0, 32'hDEADBEEF, cyc + 1);
    tick();
    wr_en = 1'b0;
    push(0, 32'h11111111, cyc + 1);
    tick();

    // owner 0 releases while op_en stays high; owner 1 ops before any write
    rel = 4'b0001; req = 4'b0010; op_data = 32'h5A5A5A5A;
    push(2, 0, cyc + 1 + SD);
    push(1, 1, cyc + 2 + SD);
    tick();
    rel = '0;
    chk("scrub_grant", 32'(o_grant), 32'h0);
    chk("scrub_op_out", o_op_out, 32'h0);
    chk("scrub_buf", dut.r_buf, 32'h0);
    repeat (1 + SD) tick();
    tick();
    op_en = 1'b0;
    chk("unloaded_op_out", o_op_out, 32'h0);

    req = 4'b1111;
    hand_over(1, 2);
    hand_over(2, 3);
    hand_over(3, 0);

    // owner 0 never releases: revocation after MH owned cycles
    g0 = cyc;
    wr_en = 1'b1; wr_data = 32'hCAFEF00D; rel = 4'b0100; req = 4'b0010;
    push(3, 0, g0 + MH);
    push(2, 0, g0 + MH + SD);
    push(1, 1, g0 + MH + SD + 1);
    tick();
    wr_en = 1'b0; rel = '0;
    tick();
    chk("nonowner_release", 32'(o_grant), 32'h1);
    while (cyc < g0 + MH) tick();
    chk("revoke_grant", 32'(o_grant), 32'h0);
    chk("revoke_buf", dut.r_buf, 32'h0);
    while (cyc < g0 + MH + SD + 1) tick();

    // release beats a same-cycle write, then reset lands mid-scrub
    rel = 4'b0010; wr_en = 1'b1; wr_data = 32'h12345678; req = '0;
    tick();
    rel = '0; wr_en = 1'b0;
    chk("rel_wr_buf", dut.r_buf, 32'h0);
    chk("rel_wr_loaded", 32'(dut.r_loaded), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(o_grant), 32'h0);
    chk("mid_rst_owner_id", 32'(o_owner_id), 32'h0);
    chk("mid_rst_op_out", o_op_out, 32'h0);
    chk("mid_rst_scrub_done", 32'(o_scrub_done), 32'h0);
    chk("mid_rst_scrub_err", 32'(o_scrub_err), 32'h0);
    rst = 1'b0;
    repeat (4) tick();
    req = 4'b1001;
    push(1, 0, cyc + 1);
    repeat (2) tick();

    chk("final_scrub_err", 32'(o_scrub_err), 32'h0);
    chk("left_op", q_op.size(), 32'h0);
    chk("left_grant", q_gnt.size(), 32'h0);
    chk("left_scrub_done", q_sd.size(), 32'h0);
    chk("left_revoked", q_rev.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
